// File: rtl/kugelblitz_axil_master_if.sv
// kugelblitz_axil_master_if: AXI-lite bus (write and read channels) between an initiator and a register slave.
interface kugelblitz_axil_master_if #(
    parameter int AXIL_DATA_WIDTH = 32,
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8
);
    logic [AXIL_ADDR_WIDTH-1:0] awaddr;
    logic [2:0]                 awprot;
    logic                       awvalid;
    logic                       awready;
    logic [AXIL_DATA_WIDTH-1:0] wdata;
    logic [AXIL_STRB_WIDTH-1:0] wstrb;
    logic                       wvalid;
    logic                       wready;
    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       bready;
    logic [AXIL_ADDR_WIDTH-1:0] araddr;
    logic [2:0]                 arprot;
    logic                       arvalid;
    logic                       arready;
    logic [AXIL_DATA_WIDTH-1:0] rdata;
    logic [1:0]                 rresp;
    logic                       rvalid;
    logic                       rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/kugelblitz_axil_master.sv
// kugelblitz_axil_master: turns a command/response stream into single outstanding AXI-lite
// accesses, with a response-phase timeout so a hung slave cannot wedge the sequencer.
module kugelblitz_axil_master #(
    parameter int         AXIL_DATA_WIDTH = 32,
    parameter int         AXIL_ADDR_WIDTH = 32,
    parameter int         AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
    parameter int         TIMEOUT_CYCLES  = 1024,
    parameter logic [2:0] AXIL_PROT       = 3'b010
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXIL_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXIL_DATA_WIDTH-1:0] cmd_data,
    input  logic [AXIL_STRB_WIDTH-1:0] cmd_strb,
    input  logic                       cmd_write,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    output logic [AXIL_DATA_WIDTH-1:0] rsp_data,
    output logic [1:0]                 rsp_resp,
    output logic                       rsp_write,
    output logic                       rsp_timeout,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    kugelblitz_axil_master_if.master   m_axil
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, WR_RESP, RD_RESP, RSP, RSP_DRAIN} state_t;

    state_t                     state, state_n;
    logic [AXIL_ADDR_WIDTH-1:0] addr;
    logic [AXIL_DATA_WIDTH-1:0] data;
    logic [AXIL_STRB_WIDTH-1:0] strb;
    logic                       wr;
    logic                       aw_done, w_done, rsp_done, late_done;
    logic [CW-1:0]              cnt;
    logic                       aw_fin, w_fin, resp_in, in_resp, expired, rsp_fin, late_fin;

    assign cmd_ready      = state == IDLE;
    assign m_axil.awaddr  = addr;
    assign m_axil.awprot  = AXIL_PROT;
    assign m_axil.awvalid = state == WR_REQ && !aw_done;
    assign m_axil.wdata   = data;
    assign m_axil.wstrb   = strb;
    assign m_axil.wvalid  = state == WR_REQ && !w_done;
    assign m_axil.araddr  = addr;
    assign m_axil.arprot  = AXIL_PROT;
    assign m_axil.arvalid = state == RD_REQ;
    // After a timeout the ready stays up until the late response has been swallowed.
    assign m_axil.bready  = state == WR_RESP || (state == RSP_DRAIN && wr && !late_done);
    assign m_axil.rready  = state == RD_RESP || (state == RSP_DRAIN && !wr && !late_done);
    assign rsp_valid      = state == RSP || (state == RSP_DRAIN && !rsp_done);
    assign rsp_write      = wr;

    assign aw_fin   = aw_done || m_axil.awready;
    assign w_fin    = w_done || m_axil.wready;
    assign resp_in  = wr ? m_axil.bvalid : m_axil.rvalid;
    assign in_resp  = state == WR_RESP || state == RD_RESP;
    assign expired  = cnt == CW'(TIMEOUT_CYCLES - 1);
    assign rsp_fin  = rsp_done || rsp_ready;
    assign late_fin = late_done || resp_in;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:             state_n = cmd_valid ? (cmd_write ? WR_REQ : RD_REQ) : IDLE;
            WR_REQ:           state_n = aw_fin && w_fin ? WR_RESP : WR_REQ;
            RD_REQ:           state_n = m_axil.arready ? RD_RESP : RD_REQ;
            WR_RESP, RD_RESP: state_n = resp_in ? RSP : expired ? RSP_DRAIN : state;
            RSP:              state_n = rsp_ready ? IDLE : RSP;
            RSP_DRAIN:        state_n = rsp_fin && late_fin ? IDLE : RSP_DRAIN;
            default:          state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            addr        <= '0;
            data        <= '0;
            strb        <= '0;
            wr          <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_done    <= 1'b0;
            late_done   <= 1'b0;
            cnt         <= '0;
            rsp_data    <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && cmd_valid) begin
                addr <= cmd_addr;
                data <= cmd_data;
                strb <= cmd_strb;
                wr   <= cmd_write;
            end
            aw_done   <= state == WR_REQ && aw_fin && !w_fin;
            w_done    <= state == WR_REQ && w_fin && !aw_fin;
            cnt       <= in_resp ? cnt + 1'b1 : '0;
            rsp_done  <= state == RSP_DRAIN && rsp_fin && !late_fin;
            late_done <= state == RSP_DRAIN && late_fin && !rsp_fin;
            // A response landing on the final counted cycle still wins over the timeout.
            if (in_resp && (resp_in || expired)) begin
                rsp_resp    <= resp_in ? (wr ? m_axil.bresp : m_axil.rresp) : 2'b11;
                rsp_data    <= resp_in && !wr ? m_axil.rdata : '0;
                rsp_timeout <= !resp_in;
            end
        end
    end
endmodule
